// File: rtl/ctl_decode_pipe.sv
// MIPS D-stage control decoder with D->E pipeline register, bubble insertion,
// illegal-opcode flagging and a mul/div occupancy tracker that requests stalls.
module ctl_decode_pipe #(
    parameter int ALUCTL_W = 5,
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid_d,
    input  logic [5:0]          opcode_d,
    input  logic [5:0]          funct_d,
    input  logic [4:0]          rt_d,
    input  logic                stall_in,
    input  logic                flush_e,
    output logic                stall_req,
    output logic                muldiv_busy,
    output logic                muldiv_done,
    output logic                valid_e,
    output logic                reg_write_e,
    output logic                mem_to_reg_e,
    output logic                mem_write_e,
    output logic                branch_e,
    output logic                alu_src_e,
    output logic                reg_dst_e,
    output logic                illegal_e,
    output logic [2:0]          branch_type_e,
    output logic [ALUCTL_W-1:0] alu_ctl_e
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);

    logic             reg_write_d;
    logic             mem_to_reg_d;
    logic             mem_write_d;
    logic             branch_d;
    logic             alu_src_d;
    logic             reg_dst_d;
    logic             illegal_d;
    logic [2:0]       branch_type_d;
    logic [4:0]       alu_code;
    logic             is_mul;
    logic             is_div;
    logic             is_hilo;
    logic             advance;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        reg_write_d   = 1'b0;
        mem_to_reg_d  = 1'b0;
        mem_write_d   = 1'b0;
        branch_d      = 1'b0;
        alu_src_d     = 1'b0;
        reg_dst_d     = 1'b0;
        illegal_d     = 1'b0;
        branch_type_d = 3'd0;
        alu_code      = 5'b00000;
        is_mul        = 1'b0;
        is_div        = 1'b0;
        is_hilo       = 1'b0;
        case (opcode_d)
            6'b000000: begin
                reg_write_d = 1'b1;
                reg_dst_d   = 1'b1;
                case (funct_d)
                    6'b000000, 6'b000100: alu_code = 5'b00101;
                    6'b000010, 6'b000110: alu_code = 5'b01000;
                    6'b000011:            alu_code = 5'b01011;
                    6'b010000, 6'b010010: begin
                        alu_code = 5'b00010;
                        is_hilo  = 1'b1;
                    end
                    6'b011000, 6'b011001: begin
                        reg_write_d = 1'b0;
                        reg_dst_d   = 1'b0;
                        is_mul      = 1'b1;
                        alu_code    = funct_d[0] ? 5'b10101 : 5'b00100;
                    end
                    6'b011010, 6'b011011: begin
                        reg_write_d = 1'b0;
                        reg_dst_d   = 1'b0;
                        is_div      = 1'b1;
                        alu_code    = funct_d[0] ? 5'b10100 : 5'b00011;
                    end
                    6'b100000: alu_code = 5'b10010;
                    6'b100001: alu_code = 5'b00010;
                    6'b100010: alu_code = 5'b10011;
                    6'b100011: alu_code = 5'b00110;
                    6'b100100: alu_code = 5'b00000;
                    6'b100101: alu_code = 5'b00001;
                    6'b100110: alu_code = 5'b01001;
                    6'b101010: alu_code = 5'b00111;
                    6'b101011: alu_code = 5'b01010;
                    default: begin
                        reg_write_d = 1'b0;
                        reg_dst_d   = 1'b0;
                        illegal_d   = 1'b1;
                    end
                endcase
            end
            6'b001000: begin alu_src_d = 1'b1; reg_write_d = 1'b1; alu_code = 5'b10010; end
            6'b001001: begin alu_src_d = 1'b1; reg_write_d = 1'b1; alu_code = 5'b00010; end
            6'b001100: begin alu_src_d = 1'b1; reg_write_d = 1'b1; alu_code = 5'b00000; end
            6'b001101: begin alu_src_d = 1'b1; reg_write_d = 1'b1; alu_code = 5'b00001; end
            6'b001110: begin alu_src_d = 1'b1; reg_write_d = 1'b1; alu_code = 5'b01001; end
            6'b001010: begin alu_src_d = 1'b1; reg_write_d = 1'b1; alu_code = 5'b00111; end
            6'b001011: begin alu_src_d = 1'b1; reg_write_d = 1'b1; alu_code = 5'b01010; end
            6'b100011: begin
                alu_src_d    = 1'b1;
                mem_to_reg_d = 1'b1;
                reg_write_d  = 1'b1;
                alu_code     = 5'b00010;
            end
            6'b101011: begin
                alu_src_d   = 1'b1;
                mem_write_d = 1'b1;
                alu_code    = 5'b00010;
            end
            6'b000100: begin branch_d = 1'b1; branch_type_d = 3'd0; alu_code = 5'b00110; end
            6'b000101: begin branch_d = 1'b1; branch_type_d = 3'd1; alu_code = 5'b00110; end
            6'b000111: begin branch_d = 1'b1; branch_type_d = 3'd3; alu_code = 5'b00110; end
            6'b000110: begin branch_d = 1'b1; branch_type_d = 3'd4; alu_code = 5'b00110; end
            6'b000001: begin
                // REGIMM: rt selects the compare-against-zero flavour
                case (rt_d)
                    5'b00001: begin branch_d = 1'b1; branch_type_d = 3'd2; alu_code = 5'b00110; end
                    5'b00000: begin branch_d = 1'b1; branch_type_d = 3'd5; alu_code = 5'b00110; end
                    default:  illegal_d = 1'b1;
                endcase
            end
            default: illegal_d = 1'b1;
        endcase
    end

    // HI/LO consumers and new mul/div ops must wait for the unit to drain
    assign muldiv_busy = (cnt != '0);
    assign stall_req   = instr_valid_d & muldiv_busy & (is_mul | is_div | is_hilo);
    assign advance     = instr_valid_d & ~(stall_in | stall_req) & ~flush_e;

    always_comb begin
        cnt_next = cnt;
        if (advance && is_mul)
            cnt_next = CNT_W'(MUL_LAT);
        else if (advance && is_div)
            cnt_next = CNT_W'(DIV_LAT);
        else if (cnt != '0)
            cnt_next = cnt - CNT_W'(1);
    end

    // done is registered so it lines up with the final busy cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            muldiv_done <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            muldiv_done <= (cnt_next == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_e || !advance) begin
            valid_e       <= 1'b0;
            reg_write_e   <= 1'b0;
            mem_to_reg_e  <= 1'b0;
            mem_write_e   <= 1'b0;
            branch_e      <= 1'b0;
            alu_src_e     <= 1'b0;
            reg_dst_e     <= 1'b0;
            illegal_e     <= 1'b0;
            branch_type_e <= 3'd0;
            alu_ctl_e     <= '0;
        end else begin
            valid_e       <= 1'b1;
            reg_write_e   <= reg_write_d;
            mem_to_reg_e  <= mem_to_reg_d;
            mem_write_e   <= mem_write_d;
            branch_e      <= branch_d;
            alu_src_e     <= alu_src_d;
            reg_dst_e     <= reg_dst_d;
            illegal_e     <= illegal_d;
            branch_type_e <= branch_type_d;
            alu_ctl_e     <= ALUCTL_W'(alu_code);
        end
    end

endmodule

// File: tb/tb_ctl_decode_pipe.sv
// Randomised bench for ctl_decode_pipe against a table-driven decode model
// and an issue-time based occupancy model of the mul/div unit.
module tb_ctl_decode_pipe;

    localparam int ALUCTL_W = 5;
    localparam int MUL_LAT  = 4;
    localparam int DIV_LAT  = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                instr_valid_d;
    logic [5:0]          opcode_d;
    logic [5:0]          funct_d;
    logic [4:0]          rt_d;
    logic                stall_in;
    logic                flush_e;
    logic                stall_req;
    logic                muldiv_busy;
    logic                muldiv_done;
    logic                valid_e;
    logic                reg_write_e;
    logic                mem_to_reg_e;
    logic                mem_write_e;
    logic                branch_e;
    logic                alu_src_e;
    logic                reg_dst_e;
    logic                illegal_e;
    logic [2:0]          branch_type_e;
    logic [ALUCTL_W-1:0] alu_ctl_e;

    always #5 clk = ~clk;

    ctl_decode_pipe #(.ALUCTL_W(ALUCTL_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid_d(instr_valid_d),
        .opcode_d(opcode_d), .funct_d(funct_d), .rt_d(rt_d),
        .stall_in(stall_in), .flush_e(flush_e), .stall_req(stall_req),
        .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
        .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
        .mem_write_e(mem_write_e), .branch_e(branch_e), .alu_src_e(alu_src_e),
        .reg_dst_e(reg_dst_e), .illegal_e(illegal_e),
        .branch_type_e(branch_type_e), .alu_ctl_e(alu_ctl_e)
    );

    // key: 0 = opcode only, 1 = R-type funct, 2 = REGIMM rt
    // flags: {reg_write, mem_to_reg, mem_write, branch, alu_src, reg_dst, illegal}
    // cls: 0 plain, 1 mult, 2 div, 3 HI/LO read
    typedef struct {
        int         key;
        logic [5:0] op;
        logic [5:0] sel;
        logic [6:0] flags;
        logic [2:0] bt;
        logic [4:0] alu;
        int         cls;
    } entry_t;

    entry_t tbl[$];

    int vec_count = 0;
    int err_count = 0;

    int   edges = 0;
    bit   have_issue = 0;
    int   issue_e = 0;
    int   issue_lat = 0;

    logic       exp_valid;
    logic [6:0] exp_flags;
    logic [2:0] exp_bt;
    logic [4:0] exp_alu;
    logic       last_stall;
    logic       last_done;

    function automatic void add_entry(int key, logic [5:0] op, logic [5:0] sel,
                                      logic [6:0] flags, logic [2:0] bt,
                                      logic [4:0] alu, int cls);
        entry_t e;
        e.key = key; e.op = op; e.sel = sel; e.flags = flags;
        e.bt = bt; e.alu = alu; e.cls = cls;
        tbl.push_back(e);
    endfunction

    function automatic int find(logic [5:0] op, logic [5:0] fn, logic [4:0] rt);
        foreach (tbl[i]) begin
            if (tbl[i].key == 0 && op == tbl[i].op) return i;
            if (tbl[i].key == 1 && op == 6'b000000 && fn == tbl[i].sel) return i;
            if (tbl[i].key == 2 && op == 6'b000001 && rt == tbl[i].sel[4:0]) return i;
        end
        return -1;
    endfunction

    function automatic bit model_busy();
        return have_issue && edges >= issue_e && edges <= issue_e + issue_lat - 1;
    endfunction

    function automatic bit model_done();
        return have_issue && edges == issue_e + issue_lat - 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            err_count++;
            $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // One clock: drive, check stall_req mid-cycle, advance model, check E state
    task automatic applyStimulus(input bit v, input logic [5:0] op, input logic [5:0] fn,
                                 input logic [4:0] rt, input bit si, input bit fl, input bit rs);
        int  idx;
        bit  cls_md;
        bit  exp_stall;
        bit  adv;
        instr_valid_d = v;
        opcode_d      = op;
        funct_d       = fn;
        rt_d          = rt;
        stall_in      = si;
        flush_e       = fl;
        rst_n         = !rs;
        idx       = find(op, fn, rt);
        cls_md    = (idx >= 0) && (tbl[idx].cls != 0);
        exp_stall = v && model_busy() && cls_md;
        @(negedge clk);
        checkOutput("stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
        last_stall = stall_req;
        adv = v && !(si || exp_stall) && !fl;
        if (rs) begin
            exp_valid = 0; exp_flags = '0; exp_bt = '0; exp_alu = '0;
            have_issue = 0;
        end else if (adv) begin
            exp_valid = 1;
            if (idx >= 0) begin
                exp_flags = tbl[idx].flags; exp_bt = tbl[idx].bt; exp_alu = tbl[idx].alu;
                if (tbl[idx].cls == 1 || tbl[idx].cls == 2) begin
                    have_issue = 1;
                    issue_e    = edges + 1;
                    issue_lat  = (tbl[idx].cls == 1) ? MUL_LAT : DIV_LAT;
                end
            end else begin
                exp_flags = 7'b0000001; exp_bt = '0; exp_alu = '0;
            end
        end else begin
            exp_valid = 0; exp_flags = '0; exp_bt = '0; exp_alu = '0;
        end
        @(posedge clk);
        edges++;
        #1;
        checkOutput("valid_e", {31'd0, valid_e}, {31'd0, exp_valid});
        checkOutput("ctl_flags", {25'd0, reg_write_e, mem_to_reg_e, mem_write_e, branch_e,
                                  alu_src_e, reg_dst_e, illegal_e}, {25'd0, exp_flags});
        checkOutput("branch_type_e", {29'd0, branch_type_e}, {29'd0, exp_bt});
        checkOutput("alu_ctl_e", 32'(alu_ctl_e), {27'd0, exp_alu});
        checkOutput("muldiv_busy", {31'd0, muldiv_busy}, {31'd0, model_busy()});
        checkOutput("muldiv_done", {31'd0, muldiv_done}, {31'd0, model_done()});
        last_done = muldiv_done;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 6'd0, 6'd0, 5'd0, 0, 0, 0);
    endtask

    initial begin
        int     stall_cnt;
        int     done_cnt;
        entry_t e;
        logic [5:0] op, fn;
        logic [4:0] rt;

        add_entry(1, 6'd0, 6'b000000, 7'b1000010, 3'd0, 5'b00101, 0);
        add_entry(1, 6'd0, 6'b000100, 7'b1000010, 3'd0, 5'b00101, 0);
        add_entry(1, 6'd0, 6'b000010, 7'b1000010, 3'd0, 5'b01000, 0);
        add_entry(1, 6'd0, 6'b000110, 7'b1000010, 3'd0, 5'b01000, 0);
        add_entry(1, 6'd0, 6'b000011, 7'b1000010, 3'd0, 5'b01011, 0);
        add_entry(1, 6'd0, 6'b010000, 7'b1000010, 3'd0, 5'b00010, 3);
        add_entry(1, 6'd0, 6'b010010, 7'b1000010, 3'd0, 5'b00010, 3);
        add_entry(1, 6'd0, 6'b011000, 7'b0000000, 3'd0, 5'b00100, 1);
        add_entry(1, 6'd0, 6'b011001, 7'b0000000, 3'd0, 5'b10101, 1);
        add_entry(1, 6'd0, 6'b011010, 7'b0000000, 3'd0, 5'b00011, 2);
        add_entry(1, 6'd0, 6'b011011, 7'b0000000, 3'd0, 5'b10100, 2);
        add_entry(1, 6'd0, 6'b100000, 7'b1000010, 3'd0, 5'b10010, 0);
        add_entry(1, 6'd0, 6'b100001, 7'b1000010, 3'd0, 5'b00010, 0);
        add_entry(1, 6'd0, 6'b100010, 7'b1000010, 3'd0, 5'b10011, 0);
        add_entry(1, 6'd0, 6'b100011, 7'b1000010, 3'd0, 5'b00110, 0);
        add_entry(1, 6'd0, 6'b100100, 7'b1000010, 3'd0, 5'b00000, 0);
        add_entry(1, 6'd0, 6'b100101, 7'b1000010, 3'd0, 5'b00001, 0);
        add_entry(1, 6'd0, 6'b100110, 7'b1000010, 3'd0, 5'b01001, 0);
        add_entry(1, 6'd0, 6'b101010, 7'b1000010, 3'd0, 5'b00111, 0);
        add_entry(1, 6'd0, 6'b101011, 7'b1000010, 3'd0, 5'b01010, 0);
        add_entry(0, 6'b001000, 6'd0, 7'b1000100, 3'd0, 5'b10010, 0);
        add_entry(0, 6'b001001, 6'd0, 7'b1000100, 3'd0, 5'b00010, 0);
        add_entry(0, 6'b001100, 6'd0, 7'b1000100, 3'd0, 5'b00000, 0);
        add_entry(0, 6'b001101, 6'd0, 7'b1000100, 3'd0, 5'b00001, 0);
        add_entry(0, 6'b001110, 6'd0, 7'b1000100, 3'd0, 5'b01001, 0);
        add_entry(0, 6'b001010, 6'd0, 7'b1000100, 3'd0, 5'b00111, 0);
        add_entry(0, 6'b001011, 6'd0, 7'b1000100, 3'd0, 5'b01010, 0);
        add_entry(0, 6'b100011, 6'd0, 7'b1100100, 3'd0, 5'b00010, 0);
        add_entry(0, 6'b101011, 6'd0, 7'b0010100, 3'd0, 5'b00010, 0);
        add_entry(0, 6'b000100, 6'd0, 7'b0001000, 3'd0, 5'b00110, 0);
        add_entry(0, 6'b000101, 6'd0, 7'b0001000, 3'd1, 5'b00110, 0);
        add_entry(0, 6'b000111, 6'd0, 7'b0001000, 3'd3, 5'b00110, 0);
        add_entry(0, 6'b000110, 6'd0, 7'b0001000, 3'd4, 5'b00110, 0);
        add_entry(2, 6'b000001, 6'b000001, 7'b0001000, 3'd2, 5'b00110, 0);
        add_entry(2, 6'b000001, 6'b000000, 7'b0001000, 3'd5, 5'b00110, 0);

        applyStimulus(0, 6'd0, 6'd0, 5'd0, 0, 0, 1);
        applyStimulus(0, 6'd0, 6'd0, 5'd0, 0, 0, 1);

        applyStimulus(1, 6'b001001, 6'd0, 5'd0, 0, 0, 0);
        applyStimulus(1, 6'b000000, 6'b100010, 5'd0, 0, 0, 0);
        applyStimulus(1, 6'b000001, 6'd0, 5'b00000, 0, 0, 0);
        applyStimulus(1, 6'b000001, 6'd0, 5'b00001, 0, 0, 0);
        applyStimulus(1, 6'b000001, 6'd0, 5'b00011, 0, 0, 0);
        applyStimulus(1, 6'b111111, 6'd0, 5'd0, 0, 0, 0);

        applyStimulus(1, 6'b000000, 6'b011010, 5'd0, 0, 0, 0);
        stall_cnt = 0;
        done_cnt  = 0;
        for (int i = 0; i < DIV_LAT + 8; i++) begin
            applyStimulus(1, 6'b000000, 6'b010010, 5'd0, 0, 0, 0);
            if (last_stall) stall_cnt++;
            if (last_done) done_cnt++;
            if (exp_valid) break;
        end
        checkOutput("mflo_stall_cycles", stall_cnt, DIV_LAT);
        checkOutput("div_done_pulses", done_cnt, 1);

        applyStimulus(1, 6'b000000, 6'b011000, 5'd0, 0, 1, 0);
        applyStimulus(1, 6'b000000, 6'b011001, 5'd0, 1, 0, 0);
        idle(1);

        applyStimulus(1, 6'b000000, 6'b011000, 5'd0, 0, 0, 0);
        for (int i = 0; i < MUL_LAT + 2; i++)
            applyStimulus(1, 6'b000000, 6'b011011, 5'd0, 0, 0, 0);
        applyStimulus(1, 6'b001101, 6'd0, 5'd0, 1, 1, 0);
        for (int i = 0; i < 21; i++)
            applyStimulus(1, 6'b100011, 6'd0, 5'd0, 0, 0, 0);
        applyStimulus(1, 6'b101011, 6'd0, 5'd0, 0, 0, 1);
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                e  = tbl[$urandom_range(0, tbl.size() - 1)];
                op = (e.key == 1) ? 6'b000000 : e.op;
                fn = (e.key == 1) ? e.sel : 6'($urandom);
                rt = (e.key == 2) ? e.sel[4:0] : 5'($urandom);
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
                rt = 5'($urandom);
            end
            applyStimulus($urandom_range(0, 9) != 0, op, fn, rt,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                          $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
